freq_divider_by4: RTL and testbench
===================================

Name: freq_divider_by4

Overview:
- Synchronous clock divider producing a square wave at exactly 1/4 of the input clock frequency with 50% duty cycle.
- Used as a low-rate enable or strobe source and as a slow clock for downstream logic.
- Output comes directly from a flip-flop, so it is glitch-free and phase-locked to rising edges of the input clock.

Parameters:
- none (division ratio fixed at 4)

Ports:
- clk      input   1  input clock; all state updates on rising edge
- rst      input   1  synchronous reset, active-high
- clk_out  output  1  divided clock, frequency clk/4, 50% duty, registered

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- rst is sampled only on the rising edge of clk. It has no asynchronous effect.
- Internal state:
  - 2-bit counter cnt, range 0..3.
  - clk_out is a register, or equivalently cnt[1] taken straight from the flop. No combinational decode may drive the port.
- Reset behaviour, on a rising edge with rst=1:
  - cnt <= 0 and clk_out <= 0.
  - Both hold at 0 for as long as rst stays high.
- Run behaviour, on a rising edge with rst=0:
  - cnt <= cnt+1, wrapping 3 -> 0.
  - clk_out <= the new value of cnt[1].
- Output sequence:
  - Let edge n be the n-th rising edge with rst=0 after reset.
  - After edge n, cnt = n mod 4 and clk_out = 1 when (n mod 4) is 2 or 3, else 0.
  - clk_out is therefore 0 after edges 1, then 1 after edges 2 and 3, then 0 after edges 4 and 5, and so on.
  - Period is 4 clk cycles: 2 cycles high, 2 cycles low.
  - First rising edge of clk_out comes at edge 2 after reset release; each later edge follows 2 cycles after the previous one.
- Power-up before any reset: output is undefined in RTL. X is acceptable in simulation until the first reset edge.
- Reset mid-operation: at the first rising edge with rst=1, clk_out goes to 0 and cnt to 0 regardless of current phase. There is no partial cycle completion. After release, the sequence restarts from edge 1 as above.
- Reset pulse of exactly one cycle: fully resets state. The next edge with rst=0 counts as edge 1.
- clk_out changes only coincident with rising edges of clk, plus clock-to-q delay. There are no transitions on falling edges.
- Wrap-around from cnt=3 to 0 produces the falling edge of clk_out. There are no extra pulses at the wrap.

Test Plan:
- Reset hold:
  - Stimulus: clk period 10 ns, rst=1 for 5 rising edges.
  - Response: clk_out=0 and cnt=0 after every edge.
- Basic division:
  - Stimulus: assert rst for 2 edges, then rst=0 for 16 edges.
  - Response: clk_out after edges 1..8 reads 0,1,1,0,0,1,1,0. Measured period is 40 ns; high time is 20 ns.
- Synchronous reset check:
  - Stimulus: while running with clk_out=1, raise rst between clock edges.
  - Response: clk_out does not change until the next rising edge, then goes to 0.
- Mid-operation reset:
  - Stimulus: run 3 edges (clk_out=1), assert rst for 1 edge, then release.
  - Response: clk_out=0 after the reset edge. The sequence restarts as 0,1,1,0 on the following edges.
- Long run:
  - Stimulus: 1000 edges with rst=0.
  - Response: exactly 250 rising edges of clk_out, with duty exactly 50% over the window. clk_out only transitions at clk rising edges.
- Power-up:
  - Stimulus: rst=0 from time 0 for 1 edge, then rst=1.
  - Response: clk_out may be X before the reset edge, and is 0 after the first rst=1 edge.

Source files
------------

// File: rtl/freq_divider_by4.sv
// freq_divider_by4: divides clk by 4 with a 50% duty cycle.
// The output is taken straight from a flop, so it cannot glitch.
module freq_divider_by4 (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);
  logic [1:0] cnt_q, cnt_d;
  logic       clk_out_q;
  assign cnt_d = cnt_q + 2'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 2'd0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= cnt_d[1];
    end
  end
  assign clk_out = clk_out_q;
endmodule

// File: tb/tb_freq_divider_by4.sv
// tb_freq_divider_by4: directed checks of reset, division, reset timing and long-run duty.
module tb_freq_divider_by4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_out;
  int   tests = 0;
  int   fails = 0;
  freq_divider_by4 dut (.clk(clk), .rst(rst), .clk_out(clk_out));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic exp_out, input logic [1:0] exp_cnt, input string tag);
    rst = r;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_out"}, {1'b0, clk_out}, {1'b0, exp_out});
    chk({tag, "_cnt"}, dut.cnt_q, exp_cnt);
  endtask
  always @(clk_out) begin
    if ($time > 0) begin
      tests++;
      assert (clk === 1'b1) else begin
        fails++;
        $error("FAIL edge_align clk=%b at %0t exp clk=1", clk, $time);
      end
    end
  end
  initial begin
    int rises, highs;
    logic prev;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd0, "reset_hold");
    for (int n = 1; n <= 16; n++)
      step(1'b0, (n % 4) >= 2, 2'(n % 4), "basic");
    step(1'b0, 1'b0, 2'd1, "pre_sync");
    step(1'b0, 1'b1, 2'd2, "pre_sync");
    rst = 1'b1;
    #2;
    chk("sync_hold", {1'b0, clk_out}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("sync_reset", {1'b0, clk_out}, 2'b00);
    step(1'b0, 1'b0, 2'd1, "mid_run");
    step(1'b0, 1'b1, 2'd2, "mid_run");
    step(1'b0, 1'b1, 2'd3, "mid_run");
    step(1'b1, 1'b0, 2'd0, "mid_reset");
    step(1'b0, 1'b0, 2'd1, "restart");
    step(1'b0, 1'b1, 2'd2, "restart");
    step(1'b0, 1'b1, 2'd3, "restart");
    step(1'b0, 1'b0, 2'd0, "restart");
    step(1'b1, 1'b0, 2'd0, "pre_long");
    rst = 1'b0;
    rises = 0;
    highs = 0;
    prev = clk_out;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (clk_out === 1'b1 && prev === 1'b0) rises++;
      if (clk_out === 1'b1) highs++;
      prev = clk_out;
    end
    chk("long_rises", rises == 250 ? 2'd1 : 2'd0, 2'd1);
    chk("long_duty", highs == 500 ? 2'd1 : 2'd0, 2'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
